// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
// Default geometry and the read-mode encodings.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  localparam int REG_READ  = 0;
  localparam int FWFT_READ = 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port,
// one asynchronous read port. Ports: i_clk, i_we/i_waddr/i_wdata, i_raddr, o_rdata.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately never reset or cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, status decode, sticky errors, read-mode mux.
// Ports: clk, rst(n), clr, wr_en/data_in, rd_en/data_out, status flags, count.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = REG_READ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              halffull,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HALF  = DEPTH / 2;

  localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LP_HALF  = HALF[ADDR_W:0];
  localparam logic [ADDR_W:0] LP_AF    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] LP_AE    = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rd_data;

  // Extra pointer bit disambiguates full from empty.
  assign w_count  = r_wptr - r_rptr;
  assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  fifo_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .i_clk  (clk),
    .i_we   (w_wr_acc && !clr),
    .i_waddr(r_wptr[ADDR_W-1:0]),
    .i_wdata(data_in),
    .i_raddr(r_rptr[ADDR_W-1:0]),
    .o_rdata(w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      if (wr_en && w_full)  r_ovf <= 1'b1;
      if (rd_en && w_empty) r_unf <= 1'b1;
    end
  end

  generate
    if (FWFT == FWFT_READ) begin : g_fwft
      assign data_out = w_rd_data;
    end else begin : g_reg
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout <= '0;
        end else if (w_rd_acc && !clr) begin
          r_dout <= w_rd_data;
        end
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign count        = w_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign halffull     = (w_count >= LP_HALF);
  assign almost_full  = (w_count >= LP_AF);
  assign almost_empty = (w_count <= LP_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  logic w_unused;
  assign w_unused = ^LP_DEPTH;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: FWFT=0 and FWFT=1 instances share stimulus,
// both compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] r_do, f_do;
  logic r_em, r_fu, r_hf, r_af, r_ae, r_ov, r_un;
  logic f_em, f_fu, f_hf, f_af, f_ae, f_ov, f_un;
  logic [AW:0] r_cnt, f_cnt;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14),
              .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(r_do), .empty(r_em), .full(r_fu),
    .halffull(r_hf), .almost_full(r_af), .almost_empty(r_ae),
    .count(r_cnt), .overflow(r_ov), .underflow(r_un)
  );

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14),
              .AE_LEVEL(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_do), .empty(f_em), .full(f_fu),
    .halffull(f_hf), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ov), .underflow(f_un)
  );

  // Reference model
  logic [DW-1:0] q[$];
  bit m_ovf, m_unf;
  logic [DW-1:0] m_dreg;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_dreg = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, " r_cnt"}, 32'(r_cnt), n);
    check({tag, " f_cnt"}, 32'(f_cnt), n);
    check({tag, " r_em"}, 32'(r_em), 32'(n == 0));
    check({tag, " f_em"}, 32'(f_em), 32'(n == 0));
    check({tag, " r_fu"}, 32'(r_fu), 32'(n == DEPTH));
    check({tag, " f_fu"}, 32'(f_fu), 32'(n == DEPTH));
    check({tag, " r_hf"}, 32'(r_hf), 32'(n >= DEPTH / 2));
    check({tag, " f_hf"}, 32'(f_hf), 32'(n >= DEPTH / 2));
    check({tag, " r_af"}, 32'(r_af), 32'(n >= 14));
    check({tag, " f_af"}, 32'(f_af), 32'(n >= 14));
    check({tag, " r_ae"}, 32'(r_ae), 32'(n <= 2));
    check({tag, " f_ae"}, 32'(f_ae), 32'(n <= 2));
    check({tag, " r_ov"}, 32'(r_ov), 32'(m_ovf));
    check({tag, " f_ov"}, 32'(f_ov), 32'(m_ovf));
    check({tag, " r_un"}, 32'(r_un), 32'(m_unf));
    check({tag, " f_un"}, 32'(f_un), 32'(m_unf));
    check({tag, " r_do"}, 32'(r_do), 32'(m_dreg));
    if (n != 0) check({tag, " f_do"}, 32'(f_do), 32'(q[0]));
  endtask

  // One clock: apply inputs, advance model on the edge, check 1ns later.
  task automatic step(input string tag, input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c);
    bit was_full, was_empty;
    wr_en = w;
    data_in = d;
    rd_en = r;
    clr = c;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (w && was_full) m_ovf = 1;
      if (r && was_empty) m_unf = 1;
      if (r && !was_empty) m_dreg = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    wr_en = 0;
    rd_en = 0;
    clr = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(r_em), 1);
    check("rst_cnt", 32'(r_cnt), 0);
    @(negedge clk);
    rst = 1;
    #1;
    check("rel_empty", 32'(r_em), 1);
    check("rel_ae", 32'(r_ae), 1);
    check("rel_cnt", 32'(r_cnt), 0);
    check("rel_full", 32'(r_fu), 0);
    check("rel_dout", 32'(r_do), 0);

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      step("fill", 1, 8'(i), 0, 0);
      if (i == 7) check("hf_at8", 32'(r_hf), 1);
      if (i == 6) check("hf_at7", 32'(r_hf), 0);
      if (i == 13) check("af_at14", 32'(r_af), 1);
      if (i == 12) check("af_at13", 32'(r_af), 0);
    end
    check("full16", 32'(r_fu), 1);
    check("cnt16", 32'(r_cnt), 16);
    step("ovf_wr", 1, 8'hEE, 0, 0);
    check("ovf_set", 32'(r_ov), 1);

    // Simultaneous at full: read accepted, write dropped
    step("full_rw", 1, 8'hDD, 1, 0);
    check("full_rw_cnt", 32'(r_cnt), 15);
    check("full_rw_do", 32'(r_do), 8'h00);
    for (int i = 0; i < 15; i++) step("drain", 0, 0, 1, 0);
    check("drain_empty", 32'(r_em), 1);
    check("drain_last", 32'(r_do), 8'h0F);

    // Simultaneous at count 5
    for (int i = 0; i < 5; i++) step("fill5", 1, 8'(8'h40 + i), 0, 0);
    step("rw5", 1, 8'h45, 1, 0);
    check("rw5_cnt", 32'(r_cnt), 5);
    for (int i = 0; i < 5; i++) step("drain5", 0, 0, 1, 0);
    check("drain5_do", 32'(r_do), 8'h45);

    // Wrap-around with write/read pairs
    for (int i = 0; i < 20; i++) begin
      step("wrap_w", 1, 8'($urandom), 0, 0);
      check("wrap_le1", 32'(r_cnt <= 1), 1);
      step("wrap_r", 0, 0, 1, 0);
      check("wrap_le1", 32'(r_cnt <= 1), 1);
    end

    // FWFT head word without rd_en
    step("fw_wr", 1, 8'hA5, 0, 0);
    check("fw_head", 32'(f_do), 8'hA5);
    step("fw_pop", 0, 0, 1, 0);
    check("fw_pop_empty", 32'(f_em), 1);

    // Underflow, then flush with simultaneous write
    step("unf_rd", 0, 0, 1, 0);
    check("unf_set", 32'(r_un), 1);
    step("ovf_again", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_clr", 1, 8'(8'h70 + i), 0, 0);
    step("clr", 1, 8'h99, 0, 1);
    check("clr_cnt", 32'(r_cnt), 0);
    check("clr_unf", 32'(r_un), 0);
    check("clr_dout_held", 32'(r_do), 32'(m_dreg));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      int wp;
      wp = (i / 100) % 2 ? 70 : 35;
      w = ($urandom_range(99) < wp);
      r = ($urandom_range(99) < 50);
      c = ($urandom_range(59) == 0);
      step("rand", w, 8'($urandom), r, c);
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) step("burst", 1, 8'($urandom), 0, 0);
    wr_en = 1;
    data_in = 8'h33;
    #2;
    rst = 0;
    #1;
    model_reset();
    check("arst_empty", 32'(r_em), 1);
    check("arst_cnt", 32'(f_cnt), 0);
    check("arst_dout", 32'(r_do), 0);
    @(posedge clk);
    #1;
    check("arst_hold_cnt", 32'(r_cnt), 0);
    @(negedge clk);
    wr_en = 0;
    rst = 1;
    #1;
    check_all("post_rst");
    step("post_wr", 1, 8'h5A, 0, 0);
    step("post_rd", 0, 0, 1, 0);
    check("post_rd_do", 32'(r_do), 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the next generation of our 16x8 FIFO: configurable data width and depth, an occupancy count, a driven `halffull` flag, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It supports a synchronous flush and two read modes: registered-output and first-word-fall-through (FWFT). It is the standard buffer between same-clock producer/consumer stages.

## Interface
- `DATA_W`, 8, data word width
- `ADDR_W`, 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 2)
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL
- `AE_LEVEL`, 2, `almost_empty` asserts when count ≤ AE_LEVEL
- `FWFT`, 0, 0 = registered read, 1 = first-word-fall-through

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous flush
- `wr_en`  in  1  write request
- `data_in`  in  DATA_W  write data
- `rd_en`  in  1  read request
- `data_out`  out  DATA_W  read data
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `halffull`  out  1  count ≥ DEPTH/2
- `almost_full`  out  1  count ≥ AF_LEVEL
- `almost_empty`  out  1  count ≤ AE_LEVEL
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a write was dropped
- `underflow`  out  1  sticky: a read was dropped

## Operation
- **Pointers.** `wptr` and `rptr` are ADDR_W+1-bit binary counters. The low ADDR_W bits address the memory. Both wrap modulo 2**(ADDR_W+1).
- **Count.** `count` = wptr − rptr, computed modulo 2**(ADDR_W+1). `full` means the MSBs differ and the low bits are equal.
- **Write accept.** A write is accepted iff `wr_en && !full`. It stores `data_in` at `mem[wptr]` and increments `wptr`.
- **Read accept.** A read is accepted iff `rd_en && !empty`. It increments `rptr`.
- **Flag basis.** Acceptance uses the flags from before the edge. A write while full is dropped even if a read is accepted in the same cycle. A read while empty is dropped even if a write is accepted in the same cycle.
- **Simultaneous read and write.** When both are accepted, `count` is unchanged.
- **FWFT=0 (registered read).** On an accepted read, `data_out` <= `mem[rptr]`. Otherwise `data_out` holds its value.
- **FWFT=1 (fall-through).** `data_out` = `mem[rptr[ADDR_W-1:0]]` combinationally, so the head word is valid whenever `!empty`. `rd_en` acts as a pop acknowledge. `data_out` is don't-care while empty.
- **Error flags.** `overflow` sets on `wr_en && full`. `underflow` sets on `rd_en && empty`. Both stay set until `clr` or reset.
- **Flush.** `clr` has priority over `wr_en`/`rd_en` that cycle. It zeroes `wptr`, `rptr`, `overflow` and `underflow`. Memory contents are not cleared. With FWFT=0, `data_out` is held.
- **Reset values.** All pointers are 0, `count`=0, `empty`=1, `full`=0, `halffull`=0. `almost_empty`=1 and `almost_full`=0 (given AF_LEVEL > 0). `overflow`=`underflow`=0. With FWFT=0, `data_out`=0.
- **Reset mid-operation.** Asserting `rst` immediately empties the FIFO asynchronously. Any in-flight request is discarded.

## Timing
- All status outputs are decoded combinationally from the registered pointers. They change only after a `clk` edge or on `rst`.
- Write at edge N: `empty` deasserts and `count` increments after edge N.
- Read latency with FWFT=0: data appears after the edge on which the read is accepted (1 cycle).
- Read latency with FWFT=1: 0 cycles; the next word is presented after the pop edge.
- Sticky flags assert after the offending edge.
- Back-to-back reads and writes are supported every cycle. Throughput is 1 word/cycle each way.

## Structure
- **Shared package `fifo_pkg`** holds:
  - default DATA_W/ADDR_W constants
  - the read-mode encodings (REG_READ=0, FWFT_READ=1)
- **Sub-module `fifo_mem`:** a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
- **`sync_fifo`** holds pointers, flag decode, the sticky flags, and the read-mode output mux.

## Test plan
Configuration for all scenarios: DATA_W=8, ADDR_W=4, AF=14, AE=2.
- **Reset.** Release `rst` → `empty`=1, `almost_empty`=1, `count`=0, `full`=0, `data_out`=0x00.
- **Fill and drain.** Write 0x00..0x0F → `halffull` asserts after the 8th write and `almost_full` after the 14th. After the 16th, `full`=1 and `count`=16. A 17th write sets `overflow` and the data is dropped. Read 16 words → 0x00..0x0F in order, then `empty`=1.
- **Simultaneous read/write.** At count=16, assert `wr_en`+`rd_en` → the read is accepted, the write is dropped, `overflow`=1, `count`=15. At count=5, do the same → `count` stays 5 and order is preserved.
- **Wrap-around.** Run 40 cycles of interleaved single write/read pairs → pointers wrap. Data matches the scoreboard and `count` never exceeds 1.
- **FWFT=1.** Write 0xA5 → `data_out`=0xA5 the cycle after the write, with no `rd_en`. Pop → `empty`=1.
- **Flush and underflow.** Read while empty → `underflow`=1. Write 3 words, then pulse `clr` together with `wr_en` → `count`=0 and both sticky flags clear. Assert `rst` mid-burst → `empty`=1 immediately.
